// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, widths and defaults for the UART transmit arbiter
package uart_pkg;
  localparam int DATA_W            = 8;
  localparam int IDX_W             = 3;
  localparam int N_REQ_DEFAULT     = 4;
  localparam int MAX_BURST_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    HOLD
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search starting one past the last owner
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] winner,
  output logic             found
);
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && ((int'(last_owner) + k) % N_REQ == i)) begin
          found  = 1'b1;
          winner = IDX_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one byte transmitter among N_REQ byte streams
// with packet-level round-robin and a per-grant burst limit
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_finish,
  output logic [IDX_W-1:0]        grant,
  output logic                    busy
);
  arb_state_t        state;
  logic [IDX_W-1:0]  last_owner;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  take_idx;
  logic              pick_found;
  logic              take;
  logic              take_last;
  logic [DATA_W-1:0] take_data;
  logic              rst_settled;
  logic              last_q;
  logic [7:0]        burst_cnt;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .winner     (pick_idx),
    .found      (pick_found)
  );

  // A byte is consumed only from IDLE (new winner) or HOLD (current owner only)
  always_comb begin
    take      = 1'b0;
    take_idx  = grant;
    take_data = '0;
    take_last = 1'b0;
    req_ready = '0;
    if (state == IDLE && rst_settled && tx_finish && pick_found) begin
      take     = 1'b1;
      take_idx = pick_idx;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (state == HOLD && grant == IDX_W'(i) && req_valid[i]) take = 1'b1;
      if (take_idx == IDX_W'(i)) begin
        take_data = req_data[DATA_W*i +: DATA_W];
        take_last = req_last[i];
      end
    end
    for (int i = 0; i < N_REQ; i++) req_ready[i] = take && (take_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      last_owner  <= IDX_W'(N_REQ - 1);
      burst_cnt   <= '0;
      last_q      <= 1'b0;
      rst_settled <= 1'b0;
    end else begin
      rst_settled <= 1'b1;
      tx_start    <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (take) begin
            state     <= LAUNCH;
            grant     <= take_idx;
            busy      <= 1'b1;
            tx_data   <= take_data;
            last_q    <= take_last;
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        LAUNCH: begin
          tx_start <= 1'b1;
          state    <= WAIT_ACK;
        end
        // tx_finish is still high from the previous byte until the transmitter reacts
        WAIT_ACK: if (!tx_finish) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (tx_finish) begin
            if (last_q || burst_cnt == 8'(MAX_BURST)) begin
              state      <= IDLE;
              busy       <= 1'b0;
              last_owner <= grant;
              burst_cnt  <= '0;
            end else begin
              state <= HOLD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter MAX_BURST, default 16, meaning the maximum bytes per grant before forced release (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the system clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits, meaning requester i presents a byte.
REQ-006 The block SHALL have port req_data, input, 8*N_REQ bits, meaning requester i's byte in bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, N_REQ bits, meaning the presented byte ends requester i's packet.
REQ-008 The block SHALL have port req_ready, output, N_REQ bits, meaning requester i's byte is consumed this cycle.
REQ-009 The block SHALL have port tx_start, output, 1 bit, meaning a one-cycle launch pulse to the byte transmitter.
REQ-010 The block SHALL have port tx_data, output, 8 bits, meaning the byte to transmit, valid while tx_start is high.
REQ-011 The block SHALL have port tx_finish, input, 1 bit, meaning the transmitter is idle (low from the cycle after tx_start until the stop bit ends).
REQ-012 The block SHALL have port grant, output, 3 bits, meaning the index of the current owner.
REQ-013 The block SHALL have port busy, output, 1 bit, meaning a requester owns the transmitter.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACK, WAIT_DONE and HOLD.
- IDLE: when tx_finish=1 and any req_valid bit is set, pick the winner by round-robin, go to LAUNCH.
REQ-015 Round-robin priority SHALL start at (last_owner+1) mod N_REQ; last_owner is updated only on release.
REQ-016 A transfer SHALL occur only in a cycle where req_valid[i] and req_ready[i] are both high; req_ready SHALL be one-hot or zero and never high without the matching req_valid.
REQ-017 The byte transfer SHALL occur in the IDLE->LAUNCH or HOLD->LAUNCH cycle; the byte, its last flag and the burst counter increment SHALL be registered then.
REQ-018 LAUNCH SHALL drive tx_start=1 with tx_data for exactly one cycle, then go to WAIT_ACK.
REQ-019 WAIT_ACK SHALL wait for tx_finish=0, then go to WAIT_DONE; tx_finish SHALL not be treated as completion in WAIT_ACK.
REQ-020 WAIT_DONE SHALL wait for tx_finish=1, then:
- release on registered last=1 or burst count = MAX_BURST: go to IDLE, set last_owner=grant, clear the burst count;
- otherwise go to HOLD.
REQ-021 HOLD SHALL keep ownership; when req_valid[grant]=1, transfer and go to LAUNCH; other requesters SHALL be ignored.
REQ-022 Latency SHALL be exactly 2 cycles from the accepted transfer to tx_start high.
REQ-023 busy SHALL be 1 in every state except IDLE; grant SHALL hold the owner index while busy and the last owner in IDLE.
REQ-024 A req_valid that changes while the transmitter is active SHALL have no effect until IDLE or HOLD.
REQ-025 If all requesters are valid simultaneously, each SHALL be served one packet in rotating order, with no starvation.
REQ-026 tx_finish=0 in IDLE SHALL block arbitration.

Reset
REQ-027 Assertion of rst_n at any time, including mid-byte, SHALL force: state=IDLE, tx_start=0, tx_data=0x00, req_ready=0, busy=0, grant=0, last_owner=N_REQ-1 (requester 0 first), burst count=0.
REQ-028 No byte SHALL be consumed, and no tx_start issued, in the first cycle after reset release.

Structure
REQ-029 The FSM state encoding, DATA_W=8 and the default N_REQ/MAX_BURST values SHALL reside in shared package uart_pkg.
REQ-030 The round-robin picker SHALL be a separate combinational sub-module, rr_pick (inputs request vector and last_owner; outputs winner index and found).

Verification
The transmitter model drops tx_finish the cycle after tx_start and raises it 10 cycles later in every scenario.
REQ-031 Req 2 sends 0xA5 with last=1 -> req_ready[2] pulses once; tx_start with 0xA5 2 cycles later; busy back to 0 after tx_finish rises; grant=2.
REQ-032 Reqs 0,1,3 each send one single-byte packet, all valid at once after reset -> tx_data order 0,1,3; no req_ready to a non-owner while busy.
REQ-033 Req 1 sends 0x11,0x22,0x33 (last on 0x33) while req 0 is continuously valid -> all three bytes precede req 0's byte.
REQ-034 MAX_BURST=4; req 3 streams 6 bytes with no last while req 0 is valid -> req 3 sends 4 bytes, req 0 sends 1 byte, then req 3 resumes.
REQ-035 rst_n is pulsed low during WAIT_DONE -> all outputs take reset values immediately; the next arbitration favours req 0.
